fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the MIPS core: owns the PC, issues word reads to instruction memory over a valid/ready request plus valid response interface, and holds each returned instruction for the controller/datapath. It consumes the `pcsrc`, `jump` and branch-target decisions the controller produces, so it is the receiving end of the controller's PC-control outputs. One instruction is in flight at a time, so the unit never fetches a wrong-path instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req_valid` out 1: read request valid.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_resp_valid` in 1: read data valid.
- `imem_resp_data` in 32: instruction word.
- `instr_valid` out 1: `instr` and `instr_pc` hold a fetched instruction.
- `instr` out 32: instruction word passed to the controller/datapath.
- `instr_pc` out 32: address of `instr`.
- `instr_ready` in 1: the core consumes `instr` this cycle.
- `pcsrc` in 1: take the branch; sampled only on consume.
- `pcbranch` in 32: branch target.
- `jump` in 1: take the jump; sampled only on consume.
- `jidx` in 26: jump index field.
- `fault` out 1: sticky misaligned-target flag.
- `retired` out 32: count of consumed instructions.

## Operation
- FSM states:
  - IDLE: entered on reset; moves to REQ unconditionally on the next edge.
  - REQ: `imem_req_valid`=1 and `imem_req_addr`=pc. On valid&ready → WAIT.
  - WAIT: on `imem_resp_valid`, latch data into `instr` and pc into `instr_pc` → HOLD.
  - HOLD: `instr_valid`=1. On `instr_ready` (consume), compute the next PC → REQ, or → FAULT if the next PC is misaligned.
  - FAULT: absorbing; all valids are 0 and `fault`=1. Only `reset` exits it.
- Next PC on consume:
  - `jump`=1 (takes priority over `pcsrc`): {`instr_pc`+4 [31:28], `jidx`, 2'b00}.
  - else `pcsrc`=1: `pcbranch`.
  - else: `instr_pc`+4.
- Address arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- The FAULT transition applies when the selected next PC has [1:0]≠0. Because jump targets always end in 2'b00, only a misaligned `pcbranch` can fault.
- `pcsrc`, `pcbranch`, `jump` and `jidx` are ignored in every cycle without a consume.
- `imem_resp_valid` outside WAIT is ignored.
- `retired` increments on every consume and wraps.

## Timing
- Reset values: state IDLE, pc=`RESET_PC`, `imem_req_valid`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `fault`=0, `retired`=0.
- Reset has priority over every other input, including a mid-request or HOLD state. An in-flight response arriving after reset is discarded because the unit is not in WAIT.
- First `imem_req_valid` appears 2 cycles after the last cycle `reset` is high: one cycle in IDLE, then REQ.
- While REQ, `imem_req_addr` is stable until accepted.
- Request accepted at edge t; response is allowed from cycle t+1. A response at cycle r gives `instr_valid` at r+1 (registered).
- Consume at cycle c gives the next request at c+1.
- Best-case throughput is one instruction per 3 cycles.
- `instr`, `instr_pc` and `instr_valid` are registered outputs. `imem_req_valid` and `imem_req_addr` are decoded from registers only; there is no combinational input-to-output path.

## Structure
- Shared package (the `common.svh` types): `fetch_state_e` {IDLE, REQ, WAIT, HOLD, FAULT}, `u26`/`u32` aliases, and a `WORD_BYTES`=4 constant.
- One natural sub-module, `fetch_npc`: combinational next-PC select. Its inputs are `instr_pc`, `pcsrc`, `pcbranch`, `jump` and `jidx`; its outputs are `npc` and `misaligned`.
- Top level holds the FSM, pc, instruction buffer and retire counter.

## Test plan
- Reset then idle memory with `imem_req_ready`=1 and a 1-cycle response: request addresses 0, 4, 8 in sequence, `instr_valid` every 3 cycles, `retired` = 3 after three consumes.
- Consume at `instr_pc`=32'h40 with `pcsrc`=1, `pcbranch`=32'h100: next `imem_req_addr`=32'h100. Same case with `pcsrc`=0: 32'h44.
- `jump`=1 and `pcsrc`=1 together at `instr_pc`=32'h1000_0010 with `jidx`=26'h40 and `pcbranch`=32'h200: jump wins, next request 32'h1000_0100.
- `instr_ready` held low for 10 cycles in HOLD: `instr` and `instr_pc` stable, no new request; `pcsrc`=1 pulsed during the hold is ignored.
- Branch to `pcbranch`=32'h102: `fault`=1 the next cycle, no further requests until `reset`; after reset, fetch restarts at `RESET_PC`.
- `reset` asserted in WAIT with the response arriving during and after reset: response dropped, `instr_valid` stays 0, first post-reset request to `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_unit_pkg;

  typedef logic [25:0] u26;
  typedef logic [31:0] u32;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_npc.sv
// Combinational next-PC select: jump beats branch, branch beats sequential.
module fetch_npc
  import fetch_unit_pkg::*;
(
  input  u32   instr_pc,
  input  logic pcsrc,
  input  u32   pcbranch,
  input  logic jump,
  input  u26   jidx,
  output u32   npc,
  output logic misaligned
);

  u32 pc_plus4;

  always_comb begin
    pc_plus4 = instr_pc + u32'(WORD_BYTES);
    if (jump) begin
      npc = {pc_plus4[31:28], jidx, 2'b00};
    end else if (pcsrc) begin
      npc = pcbranch;
    end else begin
      npc = pc_plus4;
    end
    misaligned = (npc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one request in flight, holds each instruction until
// the core consumes it, then redirects to the selected next PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic [31:0] pcbranch,
  input  logic        jump,
  input  logic [25:0] jidx,
  output logic        fault,
  output logic [31:0] retired
);

  fetch_state_e state_q, state_d;
  u32           pc_q, pc_d;
  u32           instr_q, instr_d;
  u32           instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         fault_q, fault_d;
  u32           retired_q, retired_d;

  u32   npc;
  logic npc_misaligned;

  fetch_npc u_npc (
    .instr_pc   (instr_pc_q),
    .pcsrc      (pcsrc),
    .pcbranch   (pcbranch),
    .jump       (jump),
    .jidx       (jidx),
    .npc        (npc),
    .misaligned (npc_misaligned)
  );

  // NOTE: every signal gets its hold value first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    retired_d     = retired_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          instr_d       = imem_resp_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        // Redirect inputs only matter on the consume cycle.
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          retired_d     = retired_q + 32'd1;
          if (npc_misaligned) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d    = npc;
            state_d = REQ;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      retired_q     <= retired_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign fault          = fault_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, hand-written corner
// sequences and a randomized run against a next-PC reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        pcsrc;
  logic [31:0] pcbranch;
  logic        jump;
  logic [25:0] jidx;
  logic        fault;
  logic [31:0] retired;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .pcsrc           (pcsrc),
    .pcbranch        (pcbranch),
    .jump            (jump),
    .jidx            (jidx),
    .fault           (fault),
    .retired         (retired)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_retired;

  typedef struct {
    logic [31:0] pc;
    logic        pcsrc;
    logic [31:0] br;
    logic        jump;
    logic [25:0] jidx;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Reference next PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic c_pcsrc,
                                            input logic [31:0] br, input logic c_jump,
                                            input logic [25:0] ji);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (c_jump) return (seq & 32'hF000_0000) | ({6'b0, ji} << 2);
    if (c_pcsrc) return br;
    return seq;
  endfunction

  task automatic clear_ctrl();
    pcsrc    = 1'b0;
    jump     = 1'b0;
    pcbranch = $urandom;
    jidx     = 26'($urandom);
  endtask

  // One full fetch: request (with ready stalls), response (with latency),
  // hold (with ignored noise), consume with the given redirect controls.
  task automatic do_fetch(input int rdy_dly, input int resp_dly, input int hold_dly,
                          input logic c_pcsrc, input logic [31:0] c_br,
                          input logic c_jump, input logic [25:0] c_jidx,
                          input bit use_tbl, input logic [31:0] tbl_next);
    int          waited;
    logic [31:0] data;
    logic [31:0] nxt;
    waited = 0;
    while (imem_req_valid !== 1'b1 && waited < 8) begin
      step();
      waited++;
    end
    check("req_valid", 32'(imem_req_valid), 32'd1);
    check("req_addr", imem_req_addr, exp_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'($urandom_range(0, 1));
      imem_resp_data  = $urandom;
      step();
      check("req_held", 32'(imem_req_valid), 32'd1);
      check("req_addr_stable", imem_req_addr, exp_pc);
      check("no_instr_in_req", 32'(instr_valid), 32'd0);
    end
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("req_dropped", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < resp_dly; i++) begin
      step();
      check("wait_no_instr", 32'(instr_valid), 32'd0);
    end
    data            = mem_word(exp_pc);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("instr", instr, data);
    check("instr_pc", instr_pc, exp_pc);
    for (int i = 0; i < hold_dly; i++) begin
      pcsrc           = 1'($urandom_range(0, 1));
      jump            = 1'($urandom_range(0, 1));
      pcbranch        = $urandom;
      jidx            = 26'($urandom);
      imem_resp_valid = 1'($urandom_range(0, 1));
      imem_resp_data  = $urandom;
      imem_req_ready  = 1'b1;
      step();
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", instr, data);
      check("hold_pc", instr_pc, exp_pc);
      check("hold_no_req", 32'(imem_req_valid), 32'd0);
    end
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b0;
    pcsrc           = c_pcsrc;
    pcbranch        = c_br;
    jump            = c_jump;
    jidx            = c_jidx;
    instr_ready     = 1'b1;
    step();
    instr_ready = 1'b0;
    clear_ctrl();
    exp_retired = exp_retired + 32'd1;
    nxt = use_tbl ? tbl_next : model_npc(exp_pc, c_pcsrc, c_br, c_jump, c_jidx);
    check("retired", retired, exp_retired);
    check("consumed_valid", 32'(instr_valid), 32'd0);
    if (nxt[1:0] != 2'b00) begin
      check("fault_set", 32'(fault), 32'd1);
      check("fault_no_req", 32'(imem_req_valid), 32'd0);
    end else begin
      check("no_fault", 32'(fault), 32'd0);
      check("next_req_valid", 32'(imem_req_valid), 32'd1);
      check("next_req_addr", imem_req_addr, nxt);
    end
    exp_pc = nxt;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step();
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_retired", retired, 32'd0);
    end
    reset = 1'b0;
    step();
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);
    exp_pc      = RESET_PC;
    exp_retired = 32'd0;
  endtask

  initial begin
    int start;
    tbl[0] = '{32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0, 26'h0,        32'h0000_0100};
    tbl[1] = '{32'h0000_0040, 1'b0, 32'h0000_0100, 1'b0, 26'h0,        32'h0000_0044};
    tbl[2] = '{32'h1000_0010, 1'b1, 32'h0000_0200, 1'b1, 26'h40,       32'h1000_0100};
    tbl[3] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0300, 1'b0, 26'h0,        32'h0000_0000};
    tbl[4] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0300, 1'b1, 26'h3FF_FFFF, 32'h0FFF_FFFC};
    tbl[5] = '{32'h0000_0008, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'h0,        32'hFFFF_FFF0};
    tbl[6] = '{32'hF000_0000, 1'b0, 32'h0000_0000, 1'b1, 26'h1,        32'hF000_0004};

    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;
    exp_pc          = RESET_PC;
    exp_retired     = 32'd0;
    clear_ctrl();
    apply_reset(3);

    // Back-to-back fetches at 0, 4, 8: one instruction every 3 cycles.
    for (int k = 0; k < 3; k++) begin
      start = cyc;
      do_fetch(0, 0, 0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
      check("fetch_period", 32'(cyc - start), 32'd3);
    end
    check("retired_three", retired, 32'd3);

    // Long hold with redirect noise that must be ignored.
    do_fetch(0, 0, 10, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);

    // Directed next-PC table: branch to the vector PC, then apply its controls.
    for (int v = 0; v < 7; v++) begin
      do_fetch(0, 0, 0, 1'b1, tbl[v].pc, 1'b0, 26'h0, 1'b0, 32'h0);
      do_fetch(0, 1, 0, tbl[v].pcsrc, tbl[v].br, tbl[v].jump, tbl[v].jidx, 1'b1, tbl[v].exp_next);
    end

    // Randomized traffic, aligned targets only.
    for (int n = 0; n < 60; n++) begin
      do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0), $urandom & 32'hFFFF_FFFC,
               ($urandom_range(0, 3) == 0), 26'($urandom), 1'b0, 32'h0);
    end

    // Reset while WAITing, response arriving during and after reset.
    while (imem_req_valid !== 1'b1 && cyc < 90000) step();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    reset           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    check("wait_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("wait_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("wait_rst_retired", retired, 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_req_addr", imem_req_addr, RESET_PC);
    check("post_rst_instr_valid", 32'(instr_valid), 32'd0);
    step();
    check("stray_resp_ignored", 32'(instr_valid), 32'd0);
    check("req_still_pending", imem_req_addr, RESET_PC);
    imem_resp_valid = 1'b0;
    exp_pc          = RESET_PC;
    exp_retired     = 32'd0;
    do_fetch(0, 0, 0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);

    // Misaligned branch target: sticky fault until reset.
    do_fetch(0, 0, 0, 1'b1, 32'h0000_0102, 1'b0, 26'h0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b1;
      instr_ready     = 1'b1;
      pcsrc           = 1'b1;
      pcbranch        = 32'h0000_0200;
      step();
      check("fault_sticky", 32'(fault), 32'd1);
      check("fault_no_req_hold", 32'(imem_req_valid), 32'd0);
      check("fault_no_instr", 32'(instr_valid), 32'd0);
    end
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    instr_ready     = 1'b0;
    clear_ctrl();
    apply_reset(1);
    do_fetch(0, 0, 0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
